// File: rtl/quad_spinner_gen.sv
// Multi-channel quadrature spinner emulator: per-channel signed accumulators drained as AB steps,
// plus a decimated physical-encoder path with automatic source selection.
module quad_spinner_gen #(
  parameter int CHANNELS = 2,
  parameter int POS_W    = 12,
  parameter int STEP_DIV = 1500,
  parameter int ENC_DIV  = 2
) (
  input  logic                      clk_sys,
  input  logic                      reset,
  input  logic                      ce,
  input  logic [CHANNELS-1:0]       delta_valid,
  input  logic [CHANNELS*POS_W-1:0] delta,
  input  logic [2*CHANNELS-1:0]     enc_in,
  input  logic                      hw_enable,
  output logic [2*CHANNELS-1:0]     quad_out,
  output logic [CHANNELS-1:0]       src_hw,
  output logic [CHANNELS-1:0]       busy
);

  localparam int DIV_W = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);
  localparam logic [3:0] ENC_CNT = 4'(ENC_DIV);
  localparam logic [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};

  // Forward walk: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic [1:0] quad_fwd(input logic [1:0] q);
    case (q)
      2'b00:   quad_fwd = 2'b01;
      2'b01:   quad_fwd = 2'b11;
      2'b11:   quad_fwd = 2'b10;
      2'b10:   quad_fwd = 2'b00;
      default: quad_fwd = 2'b11;
    endcase
  endfunction

  // Reverse walk: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] quad_rev(input logic [1:0] q);
    case (q)
      2'b00:   quad_rev = 2'b10;
      2'b10:   quad_rev = 2'b11;
      2'b11:   quad_rev = 2'b01;
      2'b01:   quad_rev = 2'b00;
      default: quad_rev = 2'b11;
    endcase
  endfunction

  logic [DIV_W-1:0] div_r;
  logic             step_tick_s;

  assign step_tick_s = ce & (div_r == {DIV_W{1'b0}});

  // Shared step timer
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_r <= {DIV_W{1'b0}};
    end else if (ce) begin
      if (div_r == DIV_MAX) div_r <= {DIV_W{1'b0}};
      else                  div_r <= div_r + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [POS_W-1:0] pos_r, pos_nxt_s;
    logic [POS_W+1:0] pos_ext_s, dlt_ext_s, stp_ext_s, sum_s;
    logic [2:0]       top_s;
    logic [1:0]       stp_s, emu_q_r, emu_q_nxt_s;
    logic [1:0]       hw_q_r, enc_s1_r, enc_s2_r, quad_r;
    logic             busy_r, a_prev_r, dir_last_r, edge_s, dir_s, hw_step_s;
    logic             sticky_r, src_r;
    logic [3:0]       dec_cnt_r, cnt_nxt_s;
    logic [POS_W-1:0] dlt_s;

    assign dlt_s = delta[ch*POS_W +: POS_W];

    // Emulated step decision and saturating accumulate
    always_comb begin
      stp_s       = 2'b00;
      emu_q_nxt_s = emu_q_r;
      if (step_tick_s && (pos_r != {POS_W{1'b0}})) begin
        if (pos_r[POS_W-1]) begin
          stp_s       = 2'b11;
          emu_q_nxt_s = quad_fwd(emu_q_r);
        end else begin
          stp_s       = 2'b01;
          emu_q_nxt_s = quad_rev(emu_q_r);
        end
      end else begin
        stp_s       = 2'b00;
        emu_q_nxt_s = emu_q_r;
      end
      pos_ext_s = {{2{pos_r[POS_W-1]}}, pos_r};
      stp_ext_s = {{POS_W{stp_s[1]}}, stp_s};
      if (ce && delta_valid[ch]) dlt_ext_s = {{2{dlt_s[POS_W-1]}}, dlt_s};
      else                       dlt_ext_s = {(POS_W+2){1'b0}};
      sum_s = pos_ext_s + dlt_ext_s - stp_ext_s;
      top_s = sum_s[POS_W+1:POS_W-1];
      if ((top_s == 3'b000) || (top_s == 3'b111)) pos_nxt_s = sum_s[POS_W-1:0];
      else if (sum_s[POS_W+1])                     pos_nxt_s = POS_MIN;
      else                                         pos_nxt_s = POS_MAX;
    end

    // Accumulator, emulated AB state and busy flag
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        pos_r   <= {POS_W{1'b0}};
        emu_q_r <= 2'b11;
        busy_r  <= 1'b0;
      end else begin
        pos_r   <= pos_nxt_s;
        emu_q_r <= emu_q_nxt_s;
        busy_r  <= (pos_nxt_s != {POS_W{1'b0}});
      end
    end

    // Encoder edge detection and decimation counter; a direction change restarts the count
    always_comb begin
      edge_s = enc_s2_r[0] ^ a_prev_r;
      dir_s  = enc_s2_r[0] ^ enc_s2_r[1];
      if (dir_s != dir_last_r) cnt_nxt_s = 4'd1;
      else                     cnt_nxt_s = dec_cnt_r + 4'd1;
      hw_step_s = edge_s && (cnt_nxt_s == ENC_CNT);
    end

    // Physical path runs every clock, independent of ce
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        enc_s1_r   <= 2'b11;
        enc_s2_r   <= 2'b11;
        a_prev_r   <= 1'b1;
        dir_last_r <= 1'b1;
        dec_cnt_r  <= 4'd0;
        hw_q_r     <= 2'b11;
      end else begin
        enc_s1_r <= enc_in[2*ch +: 2];
        enc_s2_r <= enc_s1_r;
        a_prev_r <= enc_s2_r[0];
        if (edge_s) begin
          dir_last_r <= dir_s;
          if (hw_step_s) begin
            dec_cnt_r <= 4'd0;
            hw_q_r    <= dir_s ? quad_fwd(hw_q_r) : quad_rev(hw_q_r);
          end else begin
            dec_cnt_r <= cnt_nxt_s;
          end
        end
      end
    end

    // Source select; edges between ce pulses are remembered until the next ce
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        src_r    <= 1'b0;
        sticky_r <= 1'b0;
      end else if (ce) begin
        sticky_r <= 1'b0;
        if (!hw_enable)                 src_r <= 1'b0;
        else if (delta_valid[ch])       src_r <= 1'b0;
        else if (edge_s || sticky_r)    src_r <= 1'b1;
      end else begin
        sticky_r <= sticky_r | edge_s;
      end
    end

    // Registered output mux; both paths keep running so switching is glitch-free
    always_ff @(posedge clk_sys) begin
      if (reset) quad_r <= 2'b11;
      else       quad_r <= src_r ? hw_q_r : emu_q_r;
    end

    assign quad_out[2*ch +: 2] = quad_r;
    assign src_hw[ch]          = src_r;
    assign busy[ch]            = busy_r;
  end

endmodule

// File: tb/tb_quad_spinner_gen.sv
// Directed bench for quad_spinner_gen (2 channels, POS_W=12, STEP_DIV=1500, ENC_DIV=2).
module tb_quad_spinner_gen;
  localparam int CH = 2;
  localparam int PW = 12;
  localparam int SD = 1500;

  logic            clk_sys = 1'b0;
  logic            reset;
  logic            ce;
  logic [CH-1:0]   delta_valid;
  logic [CH*PW-1:0] delta;
  logic [2*CH-1:0] enc_in;
  logic            hw_enable;
  logic [2*CH-1:0] quad_out;
  logic [CH-1:0]   src_hw;
  logic [CH-1:0]   busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  quad_spinner_gen #(.CHANNELS(CH), .POS_W(PW), .STEP_DIV(SD), .ENC_DIV(2)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .delta_valid(delta_valid), .delta(delta),
    .enc_in(enc_in), .hw_enable(hw_enable), .quad_out(quad_out), .src_hw(src_hw), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  // ce-tick reference: the edge following a negedge with cyc%SD==0 is a step edge
  always @(posedge clk_sys) begin
    if (reset) cyc <= 0;
    else if (ce) cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic goto_phase(input int ph);
    int n = 0;
    while (((cyc % SD) != ph) && (n < 2*SD)) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 2*SD) begin
      errors++;
      $display("FAIL goto_phase timeout observed=%0d expected=%0d", cyc % SD, ph);
    end
  endtask

  task automatic apply(input int ch, input int val);
    delta_valid     = '0;
    delta[ch*PW +: PW] = val[PW-1:0];
    delta_valid[ch] = 1'b1;
    tick(1);
    delta_valid     = '0;
  endtask

  task automatic enc0(input logic [1:0] v);
    enc_in[1:0] = v;
    tick(4);
  endtask

  initial begin
    logic [1:0] seq_emu [3];
    logic [1:0] seq_hw  [4];
    logic [1:0] prev;
    seq_emu = '{2'b01, 2'b00, 2'b10};
    seq_hw  = '{2'b10, 2'b00, 2'b01, 2'b11};

    reset = 1'b1; ce = 1'b1; delta_valid = '0; delta = '0; enc_in = 4'hF; hw_enable = 1'b0;
    tick(3);
    chk("rst_quad", 32'(quad_out), 32'hF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_src", 32'(src_hw), 32'h0);
    reset = 1'b0;
    tick(10000);
    chk("idle_quad", 32'(quad_out), 32'hF);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_src", 32'(src_hw), 32'h0);

    // ch0 +3: 11 -> 01 -> 00 -> 10, one step per STEP_DIV ticks
    goto_phase(100);
    apply(0, 3);
    chk("p3_busy", 32'(busy[0]), 32'h1);
    prev = 2'b11;
    for (int i = 0; i < 3; i++) begin
      goto_phase(0);
      chk("p3_hold", 32'(quad_out[1:0]), 32'(prev));
      tick(2);
      chk("p3_step", 32'(quad_out[1:0]), 32'(seq_emu[i]));
      chk("p3_busy_step", 32'(busy[0]), (i < 2) ? 32'h1 : 32'h0);
      prev = seq_emu[i];
    end
    goto_phase(0);
    tick(2);
    chk("p3_idle", 32'(quad_out[1:0]), 32'h2);
    chk("p3_ch1", 32'(quad_out[3:2]), 32'h3);

    // ch0 -2, then +2 on the negative step edge -> pos=+1
    goto_phase(100);
    apply(0, -2);
    chk("m2_busy", 32'(busy[0]), 32'h1);
    goto_phase(0);
    apply(0, 2);
    chk("m2_busy_after", 32'(busy[0]), 32'h1);
    tick(1);
    chk("m2_neg_step", 32'(quad_out[1:0]), 32'h0);
    goto_phase(0);
    tick(2);
    chk("m2_pos_step", 32'(quad_out[1:0]), 32'h2);
    chk("m2_busy_end", 32'(busy[0]), 32'h0);

    // ch1 saturation at both ends
    goto_phase(100);
    apply(1, 2047);
    chk("sat_busy1", 32'(busy[1]), 32'h1);
    apply(1, 100);
    apply(1, -2047);
    chk("sat_hi", 32'(busy[1]), 32'h0);
    apply(1, -2048);
    apply(1, -2048);
    chk("sat_lo_busy", 32'(busy[1]), 32'h1);
    apply(1, 2047);
    chk("sat_lo_m1", 32'(busy[1]), 32'h1);
    apply(1, 1);
    chk("sat_lo", 32'(busy[1]), 32'h0);
    chk("sat_ch1_quad", 32'(quad_out[3:2]), 32'h3);

    // physical encoder, ENC_DIV=2, 8 forward A edges
    hw_enable = 1'b1;
    for (int g = 0; g < 4; g++) begin
      enc0(2'b10);
      enc0(2'b00);
      if (g == 0) chk("hw_src", 32'(src_hw[0]), 32'h1);
      enc0(2'b01);
      enc0(2'b11);
      chk("hw_fwd", 32'(quad_out[1:0]), 32'(seq_hw[g]));
    end
    enc0(2'b10);
    enc0(2'b00);
    enc0(2'b01);
    enc0(2'b11);
    enc0(2'b10);
    chk("hw_3edges", 32'(quad_out[1:0]), 32'h2);
    enc0(2'b11);
    chk("hw_rev_restart", 32'(quad_out[1:0]), 32'h2);
    enc0(2'b01);
    enc0(2'b00);
    chk("hw_rev_step", 32'(quad_out[1:0]), 32'h3);

    // hardware edge and delta_valid on the same ce edge: delta wins
    enc_in[1:0] = 2'b01;
    tick(2);
    chk("conc_pre", 32'(src_hw[0]), 32'h1);
    apply(0, 0);
    tick(1);
    chk("conc_src", 32'(src_hw[0]), 32'h0);

    // edge during ce=0 is held until the next ce
    ce = 1'b0;
    enc0(2'b00);
    chk("sticky_hold", 32'(src_hw[0]), 32'h0);
    ce = 1'b1;
    tick(1);
    chk("sticky_set", 32'(src_hw[0]), 32'h1);

    // hw_enable=0 forces emulated source
    hw_enable = 1'b0;
    tick(2);
    chk("hwdis_src", 32'(src_hw[0]), 32'h0);
    chk("hwdis_quad", 32'(quad_out[1:0]), 32'h2);
    enc0(2'b01);
    enc0(2'b11);
    enc0(2'b10);
    chk("hwdis_motion_src", 32'(src_hw), 32'h0);
    chk("hwdis_motion_quad", 32'(quad_out), 32'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
